fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//  Instruction fetch stage directly upstream of the control decoder.
//  - Owns the program counter and addresses the synchronous instruction ROM.
//  - Presents one 9-bit instruction per cycle, plus its PC and a valid flag, to the decoder/datapath.
//  - Redirects through a writable branch-target LUT, since 9-bit instructions cannot hold full targets.
//  - Sequences start/run/halt and raises done.
// PARAMETERS
//  PC_W       10      program counter / ROM address width
//  INSTR_W    9       instruction width (matches decoder input)
//  LUT_W      4       branch-target LUT index width (2**LUT_W entries of PC_W bits)
//  HALT_INSTR 9'h1FF  encoding that ends execution
// PORTS
//  clk         in   1        single clock; all state updates on rising edge
//  reset       in   1        synchronous, active-high
//  start       in   1        begin execution at PC 0 (sampled in IDLE/HALT only)
//  stall       in   1        downstream not consuming instr this cycle
//  branch_taken in  1        redirect request for the currently presented instr
//  branch_idx  in   LUT_W    LUT index of the branch target
//  lut_we      in   1        LUT write enable
//  lut_waddr   in   LUT_W    LUT write index
//  lut_wdata   in   PC_W     LUT write data (target PC)
//  imem_addr   out  PC_W     ROM address; data returns next cycle on imem_data
//  imem_data   in   INSTR_W  ROM read data (1-cycle latency)
//  instr       out  INSTR_W  instruction to decoder; 0 when instr_valid=0
//  pc          out  PC_W     address of presented instr
//  instr_valid out  1        instr/pc meaningful this cycle
//  done        out  1        level, high while in HALT
// BEHAVIOUR
//  - Reset (any state, including mid-run):
//    - state=IDLE; fetch_pc=0; pc=0; instr_valid=0; done=0; hold flag=0; all LUT entries=0.
//  - imem_addr is driven from fetch_pc at all times.
//  - FSM states: IDLE, FILL, RUN, HALT.
//  - IDLE: fetch_pc=0. start=1 -> FILL.
//  - FILL: ROM reads addr 0; fetch_pc <= 1; -> RUN. instr_valid=0.
//  - RUN: instr_valid=1 except in the squash cycle. pc = address whose ROM data is presented.
//    - Normal cycle (stall=0, branch_taken=0): instr consumed; fetch_pc <= fetch_pc+1; pc <= old fetch_pc.
//    - Stall (stall=1):
//      - fetch_pc, pc, instr and instr_valid hold.
//      - On the first stalled cycle the presented instr is captured into a hold register.
//      - The output muxes the hold register until the first cycle with stall=0.
//      - The ROM data returned during the stall is the next instruction and must not be lost or replayed twice.
//    - Branch (branch_taken=1 & stall=0 & instr_valid=1):
//      - fetch_pc <= LUT[branch_idx].
//      - The next cycle is a squash: instr_valid=0, instr=0.
//      - The cycle after that presents mem[target] with pc=target.
//      - Taken-branch cost: exactly 1 bubble.
//    - branch_taken is ignored when stall=1 or instr_valid=0.
//    - Halt: instr_valid=1 & stall=0 & instr==HALT_INSTR -> HALT. The halt word is presented once, then instr_valid=0.
//    - A branch_taken qualifying in the same cycle as the halt word is ignored; halt wins.
//  - HALT: done=1, instr_valid=0, fetch_pc holds. start=1 -> done=0, fetch_pc=0, -> FILL.
//  - start is ignored in FILL and RUN.
//  - fetch_pc+1 wraps modulo 2**PC_W (max address -> 0) with no flag.
//  - LUT:
//    - Written on lut_we in any state.
//    - A same-cycle write and branch to the same index redirects to lut_wdata (write-through bypass).
//  - Total latency from start to first valid instr: 2 cycles (FILL, then RUN with pc=0).
// TESTING
//  1. Reset, ROM[0..3]={9'h010,9'h020,9'h030,HALT}, pulse start:
//     instr_valid rises 2 cycles later; pc 0,1,2,3 on consecutive cycles; done=1 the cycle after pc=3.
//  2. LUT[2]=10'h040 written, branch_taken with branch_idx=2 at pc=1:
//     next cycle instr_valid=0; then pc=10'h040, instr=ROM[0x40].
//  3. stall high 3 cycles at pc=5:
//     pc=5 and instr=ROM[5] held all 3 cycles; then pc=6, 7 with no skip or duplicate.
//  4. stall=1 with branch_taken=1 at pc=4:
//     no redirect; after stall drops with branch_taken=0, pc=5 follows.
//  5. Run from pc=10'h3FE with no halt: pc sequence 3FE, 3FF, 000. Assert reset mid-run:
//     next cycle instr_valid=0, done=0, state IDLE, LUT cleared.
//  6. In HALT pulse start: done falls; pc=0 valid 2 cycles later.
//     Writing LUT[1]=10'h080 while branching on idx 1 in the same cycle: target=10'h080.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, addresses a 1-cycle-latency ROM and
// presents one instruction per cycle, with LUT-based branch redirect and halt.
module fetch_unit #(
  parameter int PC_W = 10,
  parameter int INSTR_W = 9,
  parameter int LUT_W = 4,
  parameter logic [INSTR_W-1:0] HALT_INSTR = {INSTR_W{1'b1}}
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [LUT_W-1:0]   branch_idx,
  input  logic               lut_we,
  input  logic [LUT_W-1:0]   lut_waddr,
  input  logic [PC_W-1:0]    lut_wdata,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc,
  output logic               instr_valid,
  output logic               done,
  output logic [1:0]         dbg_state
);

  // Handshake: instr/pc are consumed in any cycle where instr_valid=1 and
  // stall=0; with stall=1 the presented instr/pc hold until consumed.
  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2, HALT = 2'd3} state_t;

  state_t state, state_nx;
  logic [PC_W-1:0]    fetch_pc;
  logic [PC_W-1:0]    lut [2**LUT_W];
  logic [PC_W-1:0]    target;
  logic               squash;
  logic               hold_flag;
  logic [INSTR_W-1:0] hold_reg;
  logic [INSTR_W-1:0] cur_instr;
  logic               consume;
  logic               is_halt;
  logic               take_branch;

  assign imem_addr   = fetch_pc;
  assign instr_valid = (state == RUN) && !squash;
  // Once stalled, ROM data already moved on to the next word; show the held copy.
  assign cur_instr   = hold_flag ? hold_reg : imem_data;
  assign instr       = instr_valid ? cur_instr : '0;
  assign done        = (state == HALT);
  assign dbg_state   = state;

  assign consume     = instr_valid && !stall;
  assign is_halt     = consume && (cur_instr == HALT_INSTR);
  assign take_branch = consume && branch_taken && !is_halt;
  assign target      = (lut_we && (lut_waddr == branch_idx)) ? lut_wdata : lut[branch_idx];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = FILL;
      FILL: state_nx = RUN;
      RUN:  if (is_halt) state_nx = HALT;
      HALT: if (start) state_nx = FILL;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      fetch_pc  <= '0;
      pc        <= '0;
      squash    <= 1'b0;
      hold_flag <= 1'b0;
      hold_reg  <= '0;
      for (int i = 0; i < 2**LUT_W; i++) lut[i] <= '0;
    end else begin
      state <= state_nx;
      if (lut_we) lut[lut_waddr] <= lut_wdata;
      case (state)
        IDLE: begin
          fetch_pc  <= '0;
          squash    <= 1'b0;
          hold_flag <= 1'b0;
        end
        FILL: begin
          fetch_pc <= fetch_pc + PC_W'(1);
          pc       <= fetch_pc;
        end
        RUN: begin
          if (squash) begin
            // Bubble after a redirect: target address is on the ROM this cycle.
            fetch_pc <= fetch_pc + PC_W'(1);
            pc       <= fetch_pc;
            squash   <= 1'b0;
          end else if (stall) begin
            if (!hold_flag) hold_reg <= imem_data;
            hold_flag <= 1'b1;
          end else begin
            hold_flag <= 1'b0;
            if (is_halt) begin
              fetch_pc <= fetch_pc;
            end else if (take_branch) begin
              fetch_pc <= target;
              squash   <= 1'b1;
            end else begin
              fetch_pc <= fetch_pc + PC_W'(1);
              pc       <= fetch_pc;
            end
          end
        end
        HALT: begin
          squash    <= 1'b0;
          hold_flag <= 1'b0;
          if (start) fetch_pc <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
